// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: tracks in-flight register writers and MDU occupancy to drive
// D-stage stall and forwarding selects.
module hazard_scoreboard #(
    parameter int STAGES   = 3,
    parameter int TW       = 2,
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [4:0]    d_A1,
    input  logic [TW-1:0] d_Tuse1,
    input  logic [4:0]    d_A2,
    input  logic [TW-1:0] d_Tuse2,
    input  logic [4:0]    d_A3,
    input  logic [TW-1:0] d_Tnew,
    input  logic          d_MDUreq,
    input  logic          e_mdu_start,
    input  logic          e_mdu_isdiv,
    output logic          stall,
    output logic [2:0]    fwd_sel1,
    output logic [2:0]    fwd_sel2,
    output logic          mdu_busy
);
    localparam int MAX_CYC = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
    localparam int CW      = $clog2(MAX_CYC + 1);

    logic [4:0]    a3   [STAGES];
    logic [TW-1:0] tnew [STAGES];
    logic [CW-1:0] cnt;
    logic          data_stall;
    logic          mdu_stall;
    logic [2:0]    sel1;
    logic [2:0]    sel2;

    // Walk oldest to youngest so the youngest ready writer ends up selected.
    always_comb begin
        data_stall = 1'b0;
        sel1 = '0;
        sel2 = '0;
        for (int i = STAGES - 1; i >= 0; i--) begin
            if (d_A1 != '0 && a3[i] == d_A1) begin
                if (tnew[i] > d_Tuse1) data_stall = 1'b1;
                if (tnew[i] == '0) sel1 = 3'(i + 1);
            end
            if (d_A2 != '0 && a3[i] == d_A2) begin
                if (tnew[i] > d_Tuse2) data_stall = 1'b1;
                if (tnew[i] == '0) sel2 = 3'(i + 1);
            end
        end
    end

    assign mdu_busy  = cnt != '0;
    assign mdu_stall = d_MDUreq && (mdu_busy || e_mdu_start);
    assign stall     = !reset && (data_stall || mdu_stall);
    assign fwd_sel1  = reset ? 3'd0 : sel1;
    assign fwd_sel2  = reset ? 3'd0 : sel2;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < STAGES; i++) begin
                a3[i]   <= '0;
                tnew[i] <= '0;
            end
            cnt <= '0;
        end else begin
            a3[0]   <= stall ? 5'd0 : d_A3;
            tnew[0] <= stall ? '0 : d_Tnew;
            for (int i = 1; i < STAGES; i++) begin
                a3[i]   <= a3[i-1];
                tnew[i] <= (tnew[i-1] != '0) ? tnew[i-1] - TW'(1) : '0;
            end
            // A start while busy is ignored; the MDU stall keeps it from happening.
            if (e_mdu_start && cnt == '0)
                cnt <= e_mdu_isdiv ? CW'(DIV_CYC) : CW'(MULT_CYC);
            else if (cnt != '0)
                cnt <= cnt - CW'(1);
        end
    end
endmodule
